// File: rtl/decode_stage_pkg.sv
// Shared decode encodings for the RV32I(M) ID stage: opcodes, ALU/WB/data-mode
// codes and the control bundle carried in the ID/EX register.
package decode_stage_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;
    localparam logic [6:0] FUNCT7_M    = 7'h01;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_LUI    = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [2:0] DM_B  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_W  = 3'd2;
    localparam logic [2:0] DM_BU = 3'd4;
    localparam logic [2:0] DM_HU = 3'd5;

    typedef struct packed {
        logic       rd_wr_en;
        logic       mem_wr_en;
        logic       a_sel;
        logic       b_sel;
        logic       br_en;
        logic       jump;
        logic       is_load;
        logic [2:0] br_funct3;
        logic [1:0] wb_sel;
        logic [2:0] data_mode;
        logic [4:0] alu_sel;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    // Base integer op selected by funct3 when no funct7 alternate applies.
    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [4:0] alu_m(input logic [2:0] f3);
        return {2'b10, f3};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I(M) decoder: control bundle, operand usage and legality.
// Illegal words produce an all-zero bundle apart from the source indices.
module instr_decoder
    import decode_stage_pkg::*;
#(
    parameter bit EN_M = 1'b0
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        is_div,
    output logic        illegal
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    logic       is_m;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        ctrl     = '0;
        bad      = 1'b0;
        is_m     = 1'b0;
        uses_rs1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        uses_rs2 = (op == OP_OP || op == OP_STORE || op == OP_BRANCH);
        case (op)
            OP_LUI: begin
                ctrl.rd_wr_en = 1'b1;
                ctrl.b_sel    = 1'b1;
                ctrl.alu_sel  = ALU_LUI;
            end
            OP_AUIPC: begin
                ctrl.rd_wr_en = 1'b1;
                ctrl.a_sel    = 1'b1;
                ctrl.b_sel    = 1'b1;
            end
            OP_JAL: begin
                ctrl.rd_wr_en = 1'b1;
                ctrl.jump     = 1'b1;
                ctrl.a_sel    = 1'b1;
                ctrl.b_sel    = 1'b1;
                ctrl.wb_sel   = WB_SEL_PC4;
            end
            OP_JALR: begin
                bad           = (f3 != 3'd0);
                ctrl.rd_wr_en = 1'b1;
                ctrl.jump     = 1'b1;
                ctrl.b_sel    = 1'b1;
                ctrl.wb_sel   = WB_SEL_PC4;
            end
            OP_BRANCH: begin
                bad            = (f3[2:1] == 2'b01);
                ctrl.br_en     = 1'b1;
                ctrl.a_sel     = 1'b1;
                ctrl.b_sel     = 1'b1;
                ctrl.br_funct3 = f3;
            end
            OP_LOAD: begin
                bad            = (f3 == 3'd3) || (f3[2:1] == 2'b11);
                ctrl.rd_wr_en  = 1'b1;
                ctrl.b_sel     = 1'b1;
                ctrl.wb_sel    = WB_SEL_MEM;
                ctrl.data_mode = f3;
                ctrl.is_load   = 1'b1;
            end
            OP_STORE: begin
                bad            = f3[2] || (f3[1:0] == 2'b11);
                ctrl.mem_wr_en = 1'b1;
                ctrl.b_sel     = 1'b1;
                ctrl.data_mode = f3;
            end
            OP_IMM: begin
                ctrl.rd_wr_en = 1'b1;
                ctrl.b_sel    = 1'b1;
                ctrl.alu_sel  = alu_base(f3);
                // Shift-immediates reuse funct7 as an opcode extension.
                if (f3 == 3'd1)
                    bad = (f7 != FUNCT7_BASE);
                else if (f3 == 3'd5) begin
                    if (f7 == FUNCT7_ALT)
                        ctrl.alu_sel = ALU_SRA;
                    else
                        bad = (f7 != FUNCT7_BASE);
                end
            end
            OP_OP: begin
                ctrl.rd_wr_en = 1'b1;
                if (f7 == FUNCT7_BASE)
                    ctrl.alu_sel = alu_base(f3);
                else if (f7 == FUNCT7_ALT && f3 == 3'd0)
                    ctrl.alu_sel = ALU_SUB;
                else if (f7 == FUNCT7_ALT && f3 == 3'd5)
                    ctrl.alu_sel = ALU_SRA;
                else if (EN_M && f7 == FUNCT7_M) begin
                    ctrl.alu_sel = alu_m(f3);
                    is_m         = 1'b1;
                end else
                    bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if (bad)
            ctrl = '0;
        ctrl.rd  = ctrl.rd_wr_en ? instr[11:7] : 5'd0;
        ctrl.rs1 = uses_rs1 ? instr[19:15] : 5'd0;
        ctrl.rs2 = uses_rs2 ? instr[24:20] : 5'd0;
    end

    assign illegal = bad;
    assign is_div  = is_m && f3[2];

endmodule

// File: rtl/decode_stage.sv
// Registered ID stage: valid/ready issue into the ID/EX register with
// load-use bubbles, multi-cycle divide stall and EX-driven flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter bit EN_M    = 1'b0,
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_vld,
    input  logic [31:0] if_instr,
    output logic        id_rdy,
    input  logic        flush,
    input  logic        ex_rdy,
    output logic        ex_vld,
    output logic        ex_illegal,
    output logic        ex_rd_wr_en,
    output logic        ex_mem_wr_en,
    output logic        ex_a_sel,
    output logic        ex_b_sel,
    output logic        ex_br_en,
    output logic        ex_jump,
    output logic [2:0]  ex_br_funct3,
    output logic [1:0]  ex_wb_sel,
    output logic [2:0]  ex_data_mode,
    output logic [4:0]  ex_alu_sel,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic        ex_is_load
);

    localparam logic [5:0] DIV_LAT_M1 = 6'(DIV_LAT - 1);

    ctrl_t      dec;
    ctrl_t      ex_q;
    logic       ex_vld_q;
    logic       ex_illegal_q;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_div;
    logic       dec_illegal;
    logic [5:0] div_cnt;
    logic       ex_adv;
    logic       haz;
    logic       div_busy;
    logic       issue;

    instr_decoder #(.EN_M(EN_M)) u_dec (
        .instr    (if_instr),
        .ctrl     (dec),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2),
        .is_div   (is_div),
        .illegal  (dec_illegal)
    );

    assign ex_adv   = ~ex_vld_q | ex_rdy;
    assign haz      = ex_vld_q & ex_q.is_load & (ex_q.rd != 5'd0) &
                      ((uses_rs1 & (if_instr[19:15] == ex_q.rd)) |
                       (uses_rs2 & (if_instr[24:20] == ex_q.rd)));
    assign div_busy = (div_cnt != 6'd0);
    // A flush always drains fetch so the wrong-path word is dropped.
    assign id_rdy   = flush | (ex_adv & ~haz & ~div_busy);
    assign issue    = if_vld & id_rdy & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld_q     <= 1'b0;
            ex_illegal_q <= 1'b0;
            ex_q         <= '0;
            div_cnt      <= 6'd0;
        end else begin
            if (flush)
                ex_vld_q <= 1'b0;
            else if (issue) begin
                ex_vld_q     <= 1'b1;
                ex_illegal_q <= dec_illegal;
                ex_q         <= dec;
            end else if (ex_adv)
                ex_vld_q <= 1'b0;

            // The divider keeps running across flushes; only reset clears it.
            if (issue && is_div)
                div_cnt <= DIV_LAT_M1;
            else if (div_busy)
                div_cnt <= div_cnt - 6'd1;
        end
    end

    assign ex_vld       = ex_vld_q;
    assign ex_illegal   = ex_illegal_q;
    assign ex_rd_wr_en  = ex_q.rd_wr_en;
    assign ex_mem_wr_en = ex_q.mem_wr_en;
    assign ex_a_sel     = ex_q.a_sel;
    assign ex_b_sel     = ex_q.b_sel;
    assign ex_br_en     = ex_q.br_en;
    assign ex_jump      = ex_q.jump;
    assign ex_br_funct3 = ex_q.br_funct3;
    assign ex_wb_sel    = ex_q.wb_sel;
    assign ex_data_mode = ex_q.data_mode;
    assign ex_alu_sel   = ex_q.alu_sel;
    assign ex_rd        = ex_q.rd;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_is_load   = ex_q.is_load;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M enabled with short divide, base ISA)
// checked each cycle against a behavioural model plus literal directed checks.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct packed {
        logic       vld;
        logic       illegal;
        logic       rd_wr_en;
        logic       mem_wr_en;
        logic       a_sel;
        logic       b_sel;
        logic       br_en;
        logic       jump;
        logic       is_load;
        logic [2:0] br_funct3;
        logic [1:0] wb_sel;
        logic [2:0] data_mode;
        logic [4:0] alu_sel;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_vld = 1'b0;
    logic [31:0] if_instr = 32'h0;
    logic        flush = 1'b0;
    logic        ex_rdy = 1'b1;

    obs_t act [2];
    logic rdy [2];

    int   total = 0;
    int   bad = 0;
    obs_t mdl [2];
    int   div_free [2];
    int   cyc;
    int   lat [2] = '{4, 32};

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic       id_rdy, ex_vld, ex_illegal, ex_rd_wr_en, ex_mem_wr_en;
        logic       ex_a_sel, ex_b_sel, ex_br_en, ex_jump, ex_is_load;
        logic [2:0] ex_br_funct3, ex_data_mode;
        logic [1:0] ex_wb_sel;
        logic [4:0] ex_alu_sel, ex_rd, ex_rs1, ex_rs2;

        decode_stage #(.EN_M(k == 0), .DIV_LAT(k == 0 ? 4 : 32)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .if_vld       (if_vld),
            .if_instr     (if_instr),
            .id_rdy       (id_rdy),
            .flush        (flush),
            .ex_rdy       (ex_rdy),
            .ex_vld       (ex_vld),
            .ex_illegal   (ex_illegal),
            .ex_rd_wr_en  (ex_rd_wr_en),
            .ex_mem_wr_en (ex_mem_wr_en),
            .ex_a_sel     (ex_a_sel),
            .ex_b_sel     (ex_b_sel),
            .ex_br_en     (ex_br_en),
            .ex_jump      (ex_jump),
            .ex_br_funct3 (ex_br_funct3),
            .ex_wb_sel    (ex_wb_sel),
            .ex_data_mode (ex_data_mode),
            .ex_alu_sel   (ex_alu_sel),
            .ex_rd        (ex_rd),
            .ex_rs1       (ex_rs1),
            .ex_rs2       (ex_rs2),
            .ex_is_load   (ex_is_load)
        );

        assign act[k] = {ex_vld, ex_illegal, ex_rd_wr_en, ex_mem_wr_en, ex_a_sel,
                         ex_b_sel, ex_br_en, ex_jump, ex_is_load, ex_br_funct3,
                         ex_wb_sel, ex_data_mode, ex_alu_sel, ex_rd, ex_rs1, ex_rs2};
        assign rdy[k] = id_rdy;
    end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    // Reference decode from the ISA tables: legality first, then field rules.
    function automatic obs_t ref_decode(input logic [31:0] w, input bit en_m,
                                        output bit r1, output bit r2, output bit dv);
        obs_t       o;
        bit         ok;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] base [8];
        base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        o  = '0;
        dv = 1'b0;
        r1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
        r2 = op inside {OP_OP, OP_STORE, OP_BRANCH};
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL: ok = 1'b1;
            OP_JALR:   ok = (f3 == 3'd0);
            OP_BRANCH: ok = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
            OP_LOAD:   ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            OP_STORE:  ok = f3 inside {3'd0, 3'd1, 3'd2};
            OP_IMM:    ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                            (f3 == 3'd5) ? (f7 inside {7'h00, 7'h20}) : 1'b1;
            OP_OP:     ok = (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) ||
                            (en_m && f7 == 7'h01);
            default:   ok = 1'b0;
        endcase
        o.vld = 1'b1;
        if (!ok)
            o.illegal = 1'b1;
        else begin
            o.rd_wr_en  = !(op inside {OP_BRANCH, OP_STORE});
            o.mem_wr_en = (op == OP_STORE);
            o.br_en     = (op == OP_BRANCH);
            o.jump      = op inside {OP_JAL, OP_JALR};
            o.is_load   = (op == OP_LOAD);
            o.a_sel     = op inside {OP_AUIPC, OP_JAL, OP_BRANCH};
            o.b_sel     = (op != OP_OP);
            o.wb_sel    = o.jump ? WB_SEL_PC4 : o.is_load ? WB_SEL_MEM : WB_SEL_ALU;
            o.data_mode = (op inside {OP_LOAD, OP_STORE}) ? f3 : 3'd0;
            o.br_funct3 = o.br_en ? f3 : 3'd0;
            o.alu_sel   = ALU_ADD;
            if (op == OP_LUI)
                o.alu_sel = ALU_LUI;
            else if (op inside {OP_IMM, OP_OP}) begin
                if (op == OP_OP && f7 == 7'h01) begin
                    o.alu_sel = {2'b10, f3};
                    dv = f3[2];
                end else if (op == OP_OP && f7 == 7'h20 && f3 == 3'd0)
                    o.alu_sel = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5)
                    o.alu_sel = ALU_SRA;
                else
                    o.alu_sel = base[f3];
            end
            o.rd = o.rd_wr_en ? w[11:7] : 5'd0;
        end
        o.rs1 = r1 ? w[19:15] : 5'd0;
        o.rs2 = r2 ? w[24:20] : 5'd0;
        return o;
    endfunction

    function automatic bit model_rdy(input int k);
        bit r1, r2, dv, haz;
        void'(ref_decode(if_instr, k == 0, r1, r2, dv));
        haz = mdl[k].vld && mdl[k].is_load && mdl[k].rd != 5'd0 &&
              ((r1 && if_instr[19:15] == mdl[k].rd) || (r2 && if_instr[24:20] == mdl[k].rd));
        return flush || ((!mdl[k].vld || ex_rdy) && !haz && cyc >= div_free[k]);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit   r1, r2, dv, ok_rdy;
            obs_t d;
            ok_rdy = model_rdy(k);
            d = ref_decode(if_instr, k == 0, r1, r2, dv);
            if (flush)
                mdl[k].vld = 1'b0;
            else if (if_vld && ok_rdy) begin
                mdl[k] = d;
                if (dv)
                    div_free[k] = cyc + lat[k];
            end else if (!mdl[k].vld || ex_rdy)
                mdl[k].vld = 1'b0;
        end
        cyc++;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mdl[k] = '0;
            div_free[k] = 0;
        end
        cyc = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    mdl[k] = '0;
                    div_free[k] = 0;
                end
                cyc = 0;
            end else
                model_step();
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("bundle[%0d]", k), 64'(act[k]), 64'(mdl[k]));
            chk($sformatf("id_rdy[%0d]", k), 64'(rdy[k]), 64'(model_rdy(k)));
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] w;
        int          pick;
        ops  = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
                 OP_IMM, OP_OP, OP_LOAD};
        w    = $urandom();
        pick = int'($urandom_range(0, 21));
        if (pick >= 20)
            return w;
        w[6:0]   = ops[pick % 10];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_ADD  = 32'h002101B3;
    localparam logic [31:0] I_DIV  = 32'h027342B3;

    initial begin
        obs_t exp_addi;
        exp_addi          = '0;
        exp_addi.vld      = 1'b1;
        exp_addi.rd_wr_en = 1'b1;
        exp_addi.b_sel    = 1'b1;
        exp_addi.rd       = 5'd1;

        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("reset_bundle", 64'(act[0]), 64'd0);
        chk("reset_id_rdy", 64'(rdy[0]), 64'd1);

        // addi x1,x0,5
        if_vld = 1'b1; if_instr = I_ADDI; ex_rdy = 1'b1;
        tick();
        if_vld = 1'b0;
        #1;
        chk("addi_bundle", 64'(act[0]), 64'(exp_addi));

        // lw x2,0(x1) then add x3,x2,x2: one bubble
        if_vld = 1'b1; if_instr = I_LW;
        tick();
        if_instr = I_ADD;
        #1;
        chk("lu_rd_is_load", 64'({act[0].is_load, act[0].rd}), 64'({1'b1, 5'd2}));
        chk("lu_stall", 64'(rdy[0]), 64'd0);
        tick();
        chk("lu_bubble", 64'(act[0].vld), 64'd0);
        chk("lu_ready_again", 64'(rdy[0]), 64'd1);
        tick();
        chk("lu_add_issued", 64'({act[0].vld, act[0].rd, act[0].rs1, act[0].rs2}),
            64'({1'b1, 5'd3, 5'd2, 5'd2}));

        // div x5,x6,x7: M instance stalls DIV_LAT-1=3 cycles; base instance traps
        if_instr = I_DIV;
        #1;
        chk("div_accept", 64'(rdy[0]), 64'd1);
        tick();
        if_instr = I_ADDI;
        #1;
        chk("div_alu", 64'(act[0].alu_sel), 64'd20);
        chk("div_rd_m", 64'({act[0].rd_wr_en, act[0].rd}), 64'({1'b1, 5'd5}));
        chk("div_illegal_nom", 64'({act[1].vld, act[1].illegal, act[1].rd_wr_en}),
            64'({1'b1, 1'b1, 1'b0}));
        chk("div_stall1", 64'(rdy[0]), 64'd0);
        tick();
        chk("div_stall2", 64'(rdy[0]), 64'd0);
        tick();
        chk("div_stall3", 64'(rdy[0]), 64'd0);
        tick();
        chk("div_release", 64'(rdy[0]), 64'd1);
        tick();
        if_vld = 1'b0;

        // flush while EX is blocked: word consumed, EX emptied
        if_vld = 1'b1; if_instr = I_ADDI; ex_rdy = 1'b0; flush = 1'b1;
        #1;
        chk("flush_rdy", 64'(rdy[0]), 64'd1);
        tick();
        flush = 1'b0; if_vld = 1'b0; ex_rdy = 1'b1;
        #1;
        chk("flush_vld", 64'(act[0].vld), 64'd0);

        // backpressure holds the bundle for 5 cycles
        if_vld = 1'b1; if_instr = I_ADDI;
        tick();
        ex_rdy = 1'b0; if_instr = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold", 64'(act[0]), 64'(exp_addi));
            chk("bp_rdy", 64'(rdy[0]), 64'd0);
            tick();
        end
        ex_rdy = 1'b1;
        #1;
        chk("ill_accept", 64'(rdy[0]), 64'd1);
        tick();
        if_vld = 1'b0;
        #1;
        chk("ill_bundle", 64'({act[0].vld, act[0].illegal, act[0].rd_wr_en,
                               act[0].mem_wr_en, act[0].br_en, act[0].jump}),
            64'(6'b110000));

        // asynchronous reset in the middle of a divide stall
        if_vld = 1'b1; if_instr = I_DIV;
        tick();
        if_vld = 1'b0;
        #1;
        chk("rst_pre_stall", 64'(rdy[0]), 64'd0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_bundle", 64'(act[0]), 64'd0);
        chk("rst_async_rdy", 64'(rdy[0]), 64'd1);
        chk("rst_async_cnt", 64'(g_dut[0].u_dut.div_cnt), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if_vld   = ($urandom_range(0, 4) != 0);
            if_instr = rand_instr();
            ex_rdy   = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            tick();
        end
        if_vld = 1'b0;
        flush  = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I decode/control stage that replaces the purely combinational control unit with a pipelined ID stage. It sits between fetch and execute and accepts instructions over a valid/ready handshake. It generates the full control bundle plus register indices into an ID/EX pipeline register, and detects load-use hazards. It also stalls issue behind multi-cycle divides when the M extension is enabled, and honours branch flushes from EX.

## Interface
- `EN_M`, 0 — 1 enables M-extension decode (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU); 0 makes funct7=0x01 R-type illegal.
- `DIV_LAT`, 32 — total cycles a DIV/DIVU/REM/REMU occupies EX; legal range 2..64.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `if_vld` in 1 — fetch presents a valid instruction.
- `if_instr` in 32 — instruction word.
- `id_rdy` out 1 — decode consumes `if_instr` this cycle.
- `flush` in 1 — taken branch/jump resolved in EX; kill ID and EX contents.
- `ex_rdy` in 1 — EX accepts the current ID/EX register.
- `ex_vld` out 1 — ID/EX register holds a valid op.
- `ex_illegal` out 1 — op is undecodable; all write enables are 0.
- `ex_rd_wr_en`, `ex_mem_wr_en`, `ex_a_sel`, `ex_b_sel` out 1 each — same meaning as the existing control signals.
- `ex_br_en` out 1 — B-type op; EX compares using `ex_br_funct3`.
- `ex_jump` out 1 — JAL/JALR.
- `ex_br_funct3` out 3 — branch condition, raw funct3.
- `ex_wb_sel` out 2; `ex_data_mode` out 3 — the `WB_SEL_*` and `B/H/W/BU/HU` encodings.
- `ex_alu_sel` out 5 — ALU op; bit 4 set only for M ops.
- `ex_rd`, `ex_rs1`, `ex_rs2` out 5 each — register indices; unused fields are forced to 0.
- `ex_is_load` out 1 — I_TYPE_LOAD op.

## Operation
- Transfer: `ex_adv = ~ex_vld | ex_rdy`. `id_rdy = ex_adv & ~haz & ~div_busy`, and `id_rdy = 1` whenever `flush` is asserted.
- Issue: when `if_vld & id_rdy & ~flush`, the ID/EX register loads the decoded bundle and `ex_vld` goes to 1.
- Bubble: when `ex_adv` is true and there is no issue, `ex_vld` goes to 0 and the other fields hold.
- Flush (highest priority): next cycle `ex_vld=0`. The fetched instruction presented that cycle is consumed and discarded. `div_cnt` is unaffected.
- Load-use hazard: `haz = ex_vld & ex_is_load & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd))`.
  - `uses_rs1` applies to all opcodes except LUI, AUIPC and JAL.
  - `uses_rs2` applies to R, S and B types.
  - The hazard gives exactly one bubble once the load advances.
- Divide stall: `div_cnt` is 6 bits and resets to 0.
  - On issue of a divide/remainder, `div_cnt <= DIV_LAT-1`.
  - Otherwise, if `div_cnt != 0`, it decrements by 1 per cycle.
  - `div_busy = (div_cnt != 0)`.
- Illegal: an unknown opcode, or a bad funct3/funct7 combination, issues with `ex_illegal=1`. For that op `ex_rd_wr_en = ex_mem_wr_en = ex_br_en = ex_jump = 0` and `ex_vld=1`, so the downstream trap logic sees it.
- Decode values follow the existing control table:
  - I-arith: SRAI is selected only when funct7=0x20.
  - R-type: SUB/SRA are selected only when funct7=0x20.
  - Branch resolution moves to EX; `pc_sel` is no longer produced here.

## Timing
- Latency: 1 cycle from `if_vld & id_rdy` to `ex_vld`.
- Throughput: 1 op per cycle when no stall is active.
- Backpressure: while `ex_vld & ~ex_rdy`, every ex_* output is held stable and `id_rdy=0`.
- Reset: every ex_* output is 0 and `div_cnt=0`. After reset `id_rdy=1`, since `ex_vld=0`.
- Reset asserted mid-stall clears the pending bubble and the divide count immediately.
- Flush together with `haz` or `div_busy`: flush wins. The instruction is discarded and `div_cnt` keeps counting.
- `DIV_LAT` divide: `id_rdy` is 0 for exactly `DIV_LAT-1` cycles after the divide's issue cycle, even when `ex_rdy=1`.

## Structure
- `cpu_def.vh` gains these macros: the M ALU codes (`MUL`, `MULH`, `MULHSU`, `MULHU`, `DIV`, `DIVU`, `REM`, `REMU`, bit 4 = 1), and `FUNCT7_M` = 7'h01.
- Existing opcode, ALU, WB and data-mode macros are reused unchanged. The 4-bit ALU codes are zero-extended to 5 bits.
- Sub-module `instr_decoder` is purely combinational. It takes `instr` and `EN_M`, and produces the bundle plus `uses_rs1`, `uses_rs2`, `is_div` and `illegal`.
- `decode_stage` holds the handshake logic, the hazard and divide-stall logic, and the ID/EX register.

## Test plan
- Basic issue: `0x00500093` (addi x1,x0,5) with `ex_rdy=1` → next cycle `ex_vld=1`, `ex_alu_sel=ADD`, `ex_b_sel=1`, `ex_rd=1`, `ex_rs1=0`, `ex_rs2=0`, `ex_rd_wr_en=1`.
- Load-use: `0x0000A103` (lw x2,0(x1)) then `0x002101B3` (add x3,x2,x2) → one cycle with `id_rdy=0`, then a bubble with `ex_vld=0`; the add issues on the following cycle.
- Divide stall: `EN_M=1`, `DIV_LAT=4`, `0x027342B3` (div x5,x6,x7) → `ex_alu_sel=DIV`, then `id_rdy=0` for 3 cycles. With `EN_M=0` the same word → `ex_illegal=1`, `ex_rd_wr_en=0`.
- Flush: `flush=1` while `0x00500093` is presented → instruction consumed; next cycle `ex_vld=0`.
- Backpressure and illegal: with `ex_rdy=0` held for 5 cycles, all ex_* outputs stay stable and `id_rdy=0`. `0xFFFFFFFF` issued → `ex_vld=1`, `ex_illegal=1`, all write enables 0.
- Reset: `rst_n` driven low asynchronously during a divide stall → outputs 0 and `div_cnt=0` immediately, without waiting for a clock edge; `id_rdy=1`.
